// File: rtl/pc_stall_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pc_stall_scheduler
// Description : Single owner of the program-counter enable. Serialises stall
//               requests from several pipeline requesters with round-robin
//               arbitration and holds pcEn low for the requested cycle count.
//               Supports back-to-back (chained) stalls and a flush abort.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stall_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DELAY_W = 3
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic [NUM_REQ-1:0]           reqValid,
    input  logic [NUM_REQ*DELAY_W-1:0]   reqDelay,
    input  logic                         flush,
    output logic [NUM_REQ-1:0]           reqAck,
    output logic [NUM_REQ-1:0]           reqDone,
    output logic                         pcEn,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grantId
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_COUNT = 1'b1;

    localparam logic [DELAY_W-1:0] c_ZERO = '0;
    localparam logic [DELAY_W-1:0] c_ONE  = DELAY_W'(1);
    localparam logic [DELAY_W-1:0] c_TWO  = DELAY_W'(2);
    localparam logic [ID_W-1:0]    c_LAST = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_OH0  = NUM_REQ'(1);

    logic [0:0]           r_state;
    logic [0:0]           w_nextState;
    logic [DELAY_W-1:0]   r_count;
    logic [DELAY_W-1:0]   w_nextCount;
    logic [ID_W-1:0]      r_curId;
    logic [ID_W-1:0]      w_nextCurId;
    logic [ID_W-1:0]      r_rrBase;
    logic [ID_W-1:0]      w_nextRrBase;
    logic [ID_W-1:0]      w_nextGrantId;
    logic [NUM_REQ-1:0]   w_nextAck;
    logic [NUM_REQ-1:0]   w_nextDone;
    logic                 w_nextPcEn;
    logic                 w_nextBusy;

    logic [NUM_REQ-1:0]   w_elig;
    logic [2*NUM_REQ-1:0] w_rot;
    logic                 w_anyReq;
    int                   w_winSum;
    logic [ID_W-1:0]      w_winId;
    logic [DELAY_W-1:0]   w_winDelay;
    logic [NUM_REQ-1:0]   w_winOh;
    logic [NUM_REQ-1:0]   w_curOh;
    logic                 w_grant;
    logic [DELAY_W-1:0]   w_delayArr [NUM_REQ];

    // Unpack the flat delay bus into one slice per requester
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_delaySlice
        assign w_delayArr[gi] = reqDelay[gi*DELAY_W +: DELAY_W];
    end

    // Round-robin pick: rotate eligible mask so the search starts at r_rrBase
    always_comb begin
        // A requester whose ack is on the bus this cycle is already served
        w_elig   = reqValid & ~reqAck;
        w_rot    = {w_elig, w_elig} >> r_rrBase;
        w_anyReq = 1'b0;
        w_winSum = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_anyReq && w_rot[k]) begin
                w_anyReq = 1'b1;
                w_winSum = int'(r_rrBase) + k;
            end
        end
        if (w_winSum >= NUM_REQ) begin
            w_winSum = w_winSum - NUM_REQ;
        end
        w_winId    = ID_W'(w_winSum);
        w_winDelay = w_delayArr[w_winId];
        w_winOh    = c_OH0 << w_winId;
        w_curOh    = c_OH0 << r_curId;
        // Grants happen from IDLE or on the last cycle of an unflushed stall
        w_grant    = w_anyReq &&
                     ((r_state == c_IDLE) ||
                      (r_state == c_COUNT && !flush && r_count == c_ONE));
    end

    // State register and all registered outputs; reset forces pcEn high at once
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state  <= c_IDLE;
            r_count  <= c_ZERO;
            r_curId  <= '0;
            r_rrBase <= '0;
            grantId  <= '0;
            reqAck   <= '0;
            reqDone  <= '0;
            pcEn     <= 1'b1;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_count  <= w_nextCount;
            r_curId  <= w_nextCurId;
            r_rrBase <= w_nextRrBase;
            grantId  <= w_nextGrantId;
            reqAck   <= w_nextAck;
            reqDone  <= w_nextDone;
            pcEn     <= w_nextPcEn;
            busy     <= w_nextBusy;
        end
    end

    // Next-state: grant loads the counter, COUNT decrements, flush aborts
    always_comb begin
        w_nextState   = r_state;
        w_nextCount   = r_count;
        w_nextCurId   = r_curId;
        w_nextRrBase  = r_rrBase;
        w_nextGrantId = grantId;

        if (r_state == c_COUNT && flush) begin
            w_nextState = c_IDLE;
            w_nextCount = c_ZERO;
        end else if (r_state == c_COUNT && r_count != c_ONE) begin
            w_nextCount = r_count - c_ONE;
        end else if (w_grant) begin
            w_nextGrantId = w_winId;
            w_nextRrBase  = (w_winId == c_LAST) ? '0 : w_winId + ID_W'(1);
            w_nextCurId   = w_winId;
            if (w_winDelay != c_ZERO) begin
                w_nextState = c_COUNT;
                w_nextCount = w_winDelay;
            end else begin
                w_nextState = c_IDLE;
                w_nextCount = c_ZERO;
            end
        end else begin
            // Last stall cycle with nobody waiting, or IDLE with no request
            w_nextState = c_IDLE;
            w_nextCount = c_ZERO;
        end
    end

    // Output next-values: ack on grant, done on the final low cycle
    always_comb begin
        w_nextAck  = w_grant ? w_winOh : '0;
        w_nextDone = '0;
        if (w_grant && w_winDelay <= c_ONE) begin
            // Zero or one cycle stalls finish in the same cycle they are acked
            w_nextDone = w_winOh;
        end else if (r_state == c_COUNT && !flush && r_count == c_TWO) begin
            w_nextDone = w_curOh;
        end
        w_nextBusy = (w_nextState == c_COUNT);
        w_nextPcEn = !w_nextBusy;
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_stall_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_stall_scheduler
// Description : Scoreboard bench for pc_stall_scheduler. A transaction-level
//               model schedules expected ack/done events and per-cycle
//               pcEn/busy/grantId; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_stall_scheduler;

    localparam int N  = 4;
    localparam int DW = 3;

    logic           clk      = 1'b0;
    logic           rstN     = 1'b0;
    logic [N-1:0]   reqValid = '0;
    logic [N*DW-1:0] reqDelay = '0;
    logic           flush    = 1'b0;
    logic [N-1:0]   reqAck;
    logic [N-1:0]   reqDone;
    logic           pcEn;
    logic           busy;
    logic [1:0]     grantId;

    pc_stall_scheduler #(.NUM_REQ(N), .DELAY_W(DW)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .reqValid (reqValid),
        .reqDelay (reqDelay),
        .flush    (flush),
        .reqAck   (reqAck),
        .reqDone  (reqDone),
        .pcEn     (pcEn),
        .busy     (busy),
        .grantId  (grantId)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit randOn = 1'b0;

    typedef struct { int c; int id; } ev_t;
    typedef struct { logic pc; logic bz; int gid; } cy_t;
    ev_t ackQ[$];
    ev_t doneQ[$];
    cy_t cycQ[$];

    // Reference model state: stall occupancy in cycles, not registers
    bit           mStall   = 1'b0;
    int           mRem     = 0;
    int           mBase    = 0;
    int           mGid     = 0;
    logic [N-1:0] mAckMask = '0;

    // Model: decide at each edge what the next cycle must look like
    always @(posedge clk or negedge rstN) begin : model
        logic [N-1:0] elig;
        bit  canGrant;
        int  pick;
        int  idx;
        int  d;
        if (!rstN) begin
            mStall = 1'b0; mRem = 0; mBase = 0; mGid = 0; mAckMask = '0;
            ackQ.delete(); doneQ.delete(); cycQ.delete();
        end else begin
            cyc      = cyc + 1;
            elig     = reqValid & ~mAckMask;
            mAckMask = '0;
            canGrant = 1'b0;
            if (mStall) begin
                if (flush) begin
                    mStall = 1'b0;
                    // Aborted stall: its completion must never be seen
                    if (doneQ.size() > 0 && doneQ[$].c >= cyc) void'(doneQ.pop_back());
                end else begin
                    mRem = mRem - 1;
                    if (mRem == 0) begin
                        mStall   = 1'b0;
                        canGrant = 1'b1;
                    end
                end
            end else begin
                canGrant = 1'b1;
            end
            if (canGrant && elig != '0) begin
                pick = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (mBase + k) % N;
                    if (pick < 0 && elig[idx]) pick = idx;
                end
                d = int'(reqDelay[pick*DW +: DW]);
                mGid  = pick;
                mBase = (pick + 1) % N;
                mAckMask[pick] = 1'b1;
                ackQ.push_back('{cyc, pick});
                if (d == 0) begin
                    doneQ.push_back('{cyc, pick});
                end else begin
                    mStall = 1'b1;
                    mRem   = d;
                    doneQ.push_back('{cyc + d - 1, pick});
                end
            end
            cycQ.push_back('{!mStall, mStall, mGid});
        end
    end

    // Monitor: compare DUT outputs against scheduled expectations
    always @(negedge clk) begin : monitor
        cy_t          e;
        logic [N-1:0] expAck;
        logic [N-1:0] expDone;
        if (!rstN) begin
            tests++;
            if (pcEn !== 1'b1 || busy !== 1'b0 || reqAck !== '0 ||
                reqDone !== '0 || grantId !== 2'd0) begin
                fails++;
                $display("FAIL resetVals cyc=%0d got pcEn=%b busy=%b ack=%b done=%b gid=%0d want 1 0 0000 0000 0",
                         cyc, pcEn, busy, reqAck, reqDone, grantId);
            end
        end else begin
            tests++;
            if (cycQ.size() == 0) begin
                fails++;
                $display("FAIL cycleState cyc=%0d got no expectation want one", cyc);
            end else begin
                e = cycQ.pop_front();
                if (pcEn !== e.pc || busy !== e.bz || int'(grantId) != e.gid) begin
                    fails++;
                    $display("FAIL cycleState cyc=%0d got pcEn=%b busy=%b gid=%0d want pcEn=%b busy=%b gid=%0d",
                             cyc, pcEn, busy, grantId, e.pc, e.bz, e.gid);
                end
            end
            expAck = '0;
            if (ackQ.size() > 0 && ackQ[0].c == cyc) begin
                expAck[ackQ[0].id] = 1'b1;
                void'(ackQ.pop_front());
            end
            tests++;
            if (reqAck !== expAck) begin
                fails++;
                $display("FAIL reqAck cyc=%0d got %b want %b", cyc, reqAck, expAck);
            end
            expDone = '0;
            if (doneQ.size() > 0 && doneQ[0].c == cyc) begin
                expDone[doneQ[0].id] = 1'b1;
                void'(doneQ.pop_front());
            end
            tests++;
            if (reqDone !== expDone) begin
                fails++;
                $display("FAIL reqDone cyc=%0d got %b want %b", cyc, reqDone, expDone);
            end
        end
    end

    logic [N-1:0] acked;

    // One stimulus step: requesters drop after ack; optionally random traffic
    task automatic step();
        @(negedge clk);
        #1;
        acked    = reqAck;
        reqValid = reqValid & ~acked;
        flush    = 1'b0;
        if (randOn) begin
            for (int i = 0; i < N; i++) begin
                if (!reqValid[i] && !acked[i]) begin
                    reqDelay[i*DW +: DW] = DW'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) == 0) reqValid[i] = 1'b1;
                end
            end
            flush = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic doReset();
        step();
        rstN     = 1'b0;
        reqValid = '0;
        flush    = 1'b0;
        step();
        step();
        rstN = 1'b1;
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    int ackOrder[$];
    int lowCnt;
    int doneSeen;
    int firstAck;

    initial begin
        // Idle after reset
        doReset();
        repeat (20) step();

        // Single request, delay 5
        reqDelay[1*DW +: DW] = 3'd5;
        reqValid = 4'b0010;
        repeat (10) step();
        check("grantIdAfterSingle", int'(grantId), 1);

        // Three simultaneous requests after reset: order 0,1,3, 9 low cycles
        doReset();
        reqDelay = {3'd4, 3'd7, 3'd3, 3'd2};
        reqValid = 4'b1011;
        lowCnt = 0;
        ackOrder.delete();
        for (int s = 0; s < 14; s++) begin
            step();
            if (!pcEn) lowCnt++;
            for (int i = 0; i < N; i++) if (reqAck[i]) ackOrder.push_back(i);
        end
        check("chainLowCycles", lowCnt, 9);
        check("chainAckCount", ackOrder.size(), 3);
        if (ackOrder.size() == 3) begin
            check("chainOrder0", ackOrder[0], 0);
            check("chainOrder1", ackOrder[1], 1);
            check("chainOrder2", ackOrder[2], 3);
        end

        // Zero-delay request never drops pcEn
        reqDelay[2*DW +: DW] = 3'd0;
        reqValid = 4'b0100;
        lowCnt = 0;
        repeat (4) begin
            step();
            if (!pcEn) lowCnt++;
        end
        check("zeroDelayLow", lowCnt, 0);

        // Flush three cycles after grant; pending requester 3 served next
        doReset();
        reqDelay[0*DW +: DW] = 3'd7;
        reqValid = 4'b0001;
        step();
        check("flushAckSeen", int'(reqAck[0]), 1);
        reqDelay[3*DW +: DW] = 3'd2;
        reqValid[3] = 1'b1;
        doneSeen = 0;
        step();
        step();
        flush = 1'b1;
        step();
        check("pcEnAfterFlush", int'(pcEn), 1);
        for (int s = 0; s < 6; s++) begin
            if (reqDone[0]) doneSeen++;
            step();
        end
        check("noDoneAfterFlush", doneSeen, 0);
        check("grantAfterFlush", int'(grantId), 3);

        // Reset mid-stall, then requester 0 wins again
        doReset();
        reqDelay[0*DW +: DW] = 3'd6;
        reqValid = 4'b0001;
        step();
        step();
        rstN = 1'b0;
        #1;
        check("asyncResetPcEn", int'(pcEn), 1);
        check("asyncResetBusy", int'(busy), 0);
        reqValid = '0;
        step();
        step();
        rstN = 1'b1;
        reqDelay = {3'd1, 3'd0, 3'd0, 3'd1};
        reqValid = 4'b1001;
        firstAck = -1;
        repeat (5) begin
            step();
            for (int i = 0; i < N; i++) if (reqAck[i] && firstAck < 0) firstAck = i;
        end
        check("priorityAfterReset", firstAck, 0);

        // Randomised traffic with flushes
        randOn = 1'b1;
        repeat (3000) step();
        randOn = 1'b0;
        repeat (80) step();
        check("ackQueueDrained", ackQ.size(), 0);
        check("doneQueueDrained", doneQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_stall_scheduler.md
Name: pc_stall_scheduler

Overview:
Sequences the program-counter enable for the core. It collects stall requests from several pipeline requesters, such as memory wait, multiply and branch delay. Each request carries a cycle count. The block serializes requests with round-robin arbitration and holds pcEn low for exactly the requested count. It replaces ad hoc per-unit delay counters with one owner of pcEn.

Parameters:
NUM_REQ, 4, number of stall requesters (2..8)
DELAY_W, 3, width of each requested delay count; max stall per request is 2**DELAY_W-1 cycles

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  asynchronous active-low reset
reqValid  input  NUM_REQ  per-requester stall request, level; held until reqAck
reqDelay  input  NUM_REQ*DELAY_W  per-requester delay; slice i = bits [i*DELAY_W +: DELAY_W]; sampled at grant
flush  input  1  synchronous abort of the active stall
reqAck  output  NUM_REQ  one-hot, 1-cycle pulse; request i granted
reqDone  output  NUM_REQ  one-hot, 1-cycle pulse; stall for i completed
pcEn  output  1  PC advance enable; 0 while a stall is counting
busy  output  1  1 while a granted stall is counting
grantId  output  clog2(NUM_REQ)  index of last granted requester

Behaviour:
- All outputs registered. Reset (async, rstN=0):
  - pcEn=1, busy=0, reqAck=0, reqDone=0, grantId=0, count=0.
  - Round-robin pointer set so requester 0 has highest priority.
- States: IDLE, COUNT.
- Arbitration:
  - Round-robin over eligible reqValid bits, starting at (last grantId+1) mod NUM_REQ.
  - reqValid[i] is ignored in the cycle reqAck[i] is high.
  - Requester must deassert reqValid by the next edge after seeing reqAck.
- IDLE, at least one eligible request sampled at edge t, delay D = reqDelay slice:
  - D>0: at t+1, reqAck[i]=1, grantId=i, busy=1, pcEn=0, count=D; go to COUNT.
  - D=0: at t+1, reqAck[i]=1 and reqDone[i]=1 together; pcEn stays 1; stay IDLE.
- COUNT:
  - count decrements each cycle; pcEn=0 for exactly D cycles (t+1..t+D).
  - reqDone[i] pulses in cycle t+D, the last low cycle.
  - At edge ending t+D: if another eligible request exists, grant it directly. New reqAck at t+D+1; pcEn stays low with no 1-cycle gap (chained stall). A chained D=0 grant gives ack+done with pcEn=1 and returns to IDLE.
  - Otherwise pcEn=1 and busy=0 at t+D+1; go to IDLE.
- flush=1 sampled in COUNT:
  - Next cycle pcEn=1, busy=0, count=0, go to IDLE; no reqDone for the aborted stall.
  - Pending un-acked requests are kept and arbitrated normally afterwards.
  - flush in IDLE has no effect. flush has priority over a same-edge completion or chained grant.
- Width: count is DELAY_W bits, loaded only at grant; it never underflows because decrement stops at 1→done.
- reqDelay changes after grant do not affect the active stall.
- Reset mid-stall: immediate return to reset values. pcEn=1 asynchronously. The interrupted stall gets no reqDone.

Test Plan:
- Reset then idle, no requests → pcEn=1, busy=0, reqAck=0 for 20 cycles.
- reqValid=4'b0010, delay[1]=5 at edge t → reqAck[1] at t+1; pcEn=0 for t+1..t+5; reqDone[1] at t+5; pcEn=1 at t+6; grantId=1.
- reqValid=4'b1011 simultaneously, delays 2,3,x,4 after reset → grant order 0,1,3. pcEn low for 2+3+4=9 contiguous cycles; three reqAck and three reqDone pulses in order.
- delay[2]=0 request in IDLE → reqAck[2] and reqDone[2] in the same cycle; pcEn never drops.
- delay[0]=7, flush asserted 3 cycles after grant → pcEn=1 the cycle after flush; no reqDone[0]. A pending request 3 is then granted next.
- rstN pulsed low mid-stall (delay 6, cycle 2) → pcEn=1, busy=0 immediately. After release, requester 0 has priority again.
